ram_stream_loader: RTL and testbench
====================================

Name: ram_stream_loader

Overview:
- Write-side companion to the multi-port window RAM. Accepts a valid/ready pixel or coefficient stream and converts it into RAM write strobes (we, wr_addr, wr_data) at consecutive addresses from a programmed base.
- Sits between the host/frame source and the RAM. Signals completion so the window/convolution reader can start fetching 9-word windows.

Parameters:
- ADDR_WIDTH, 8, RAM address width; addresses wrap modulo 2**ADDR_WIDTH.
- DATA_WIDTH, 32, word width of stream data and RAM write data.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a load; sampled only in IDLE.
- base_addr  input  ADDR_WIDTH  first write address; captured on accepted start.
- length  input  ADDR_WIDTH+1  words to write (0..2**ADDR_WIDTH); captured on accepted start.
- in_valid  input  1  stream word present.
- in_data  input  DATA_WIDTH  stream word.
- in_ready  output  1  loader accepts in_data this cycle.
- we  output  1  RAM write enable, registered.
- wr_addr  output  ADDR_WIDTH  RAM write address, registered.
- wr_data  output  DATA_WIDTH  RAM write data, registered.
- busy  output  1  high from the cycle after an accepted start until the done pulse.
- done  output  1  one-cycle pulse after the last write is issued.
- words_written  output  ADDR_WIDTH+1  running count of beats accepted in the current/last load.

Behaviour:
- Reset: state=IDLE; in_ready=0, we=0, wr_addr=0, wr_data=0, busy=0, done=0, words_written=0. Reset mid-load abandons the load; no further writes.
- States: IDLE, LOAD, FINISH.
- IDLE, start=1, length>0: capture base_addr to addr pointer and length to remaining count, clear words_written, go to LOAD. busy=1 next cycle.
- IDLE, start=1, length=0: go to FINISH directly. No write is issued, and done pulses one cycle later.
- LOAD: in_ready=1 combinationally while remaining>0.
- A beat is accepted when in_valid&&in_ready. On the following edge: we=1, wr_addr=pointer, wr_data=in_data. The pointer increments, remaining decrements and words_written increments. Latency is exactly 1 cycle from acceptance to the write strobe.
- When no beat is accepted, we=0 the next cycle. Gaps in in_valid are allowed and produce no write.
- Full throughput: back-to-back valid beats produce back-to-back writes at 1 word/clock.
- Last beat (remaining==1 accepted): go to FINISH. in_ready drops the same edge, so no extra beat is accepted.
- FINISH: done=1 for exactly one cycle, coinciding with the cycle after the last we=1 (or the cycle after start when length=0). busy=0 in the same cycle. Return to IDLE.
- Pointer wrap: the increment is modulo 2**ADDR_WIDTH. Writing past the top address continues at 0 without error.
- length=2**ADDR_WIDTH writes every address exactly once.
- start asserted during LOAD or FINISH is ignored; it is not queued.
- words_written holds its final value in IDLE until the next accepted start.
- wr_addr and wr_data hold their last values when we=0.

Decomposition:
- Shared package: state encoding constants (IDLE, LOAD, FINISH) and default ADDR_WIDTH/DATA_WIDTH constants shared with the RAM and the window reader.
- No sub-module is needed; the pointer/count logic stays in a single module.

Test Plan:
- Reset, then start base=8'h10 length=4 with continuous valid data A0..A3 -> we high 4 consecutive cycles, wr_addr 10,11,12,13 carrying A0..A3. done pulses the cycle after the last write. words_written=4.
- Same load with in_valid toggling 1,0,1,0 -> writes appear only one cycle after each accepted beat, addresses stay contiguous, and exactly 4 writes occur.
- base=8'hFE length=4 -> wr_addr FE,FF,00,01. No extra writes.
- start with length=0 -> in_ready stays 0, no we, done pulses 2 cycles after start.
- Second start pulse in mid-load -> ignored. The count completes at the original length.
- Reset asserted after 2 of 5 beats -> we=0 next cycle, all outputs at reset values, and the loader stays in IDLE until a new start.

Source files
------------

// File: rtl/ram_stream_loader_pkg.sv
// Shared definitions for the window-RAM write path: default bus widths and
// the loader state encoding, also used by the RAM and the window reader.
package ram_stream_loader_pkg;

  localparam int unsigned LDR_ADDR_WIDTH = 8;
  localparam int unsigned LDR_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_FINISH = 2'd2
  } ldr_state_t;

endpackage

// File: rtl/ram_stream_loader.sv
// Converts a valid/ready word stream into registered RAM write strobes at
// consecutive (wrapping) addresses from a programmed base, then pulses done.
module ram_stream_loader
  import ram_stream_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = LDR_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = LDR_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   words_written
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  ldr_state_t            state, state_nxt;
  logic [ADDR_WIDTH-1:0] ptr, ptr_nxt;
  logic [CNT_W-1:0]      remaining, remaining_nxt;
  logic                  we_nxt;
  logic [ADDR_WIDTH-1:0] wr_addr_nxt;
  logic [DATA_WIDTH-1:0] wr_data_nxt;
  logic                  busy_nxt;
  logic                  done_nxt;
  logic [CNT_W-1:0]      words_nxt;
  logic                  accept;

  // Ready is combinational so the last beat closes the window on the same edge.
  assign in_ready = (state == ST_LOAD) && (remaining != '0);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      ptr           <= '0;
      remaining     <= '0;
      we            <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      words_written <= '0;
    end else begin
      state         <= state_nxt;
      ptr           <= ptr_nxt;
      remaining     <= remaining_nxt;
      we            <= we_nxt;
      wr_addr       <= wr_addr_nxt;
      wr_data       <= wr_data_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
      words_written <= words_nxt;
    end
  end

  // Next-state and registered-output values; write address/data hold by default.
  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    remaining_nxt = remaining;
    we_nxt        = 1'b0;
    wr_addr_nxt   = wr_addr;
    wr_data_nxt   = wr_data;
    busy_nxt      = busy;
    done_nxt      = 1'b0;
    words_nxt     = words_written;

    case (state)
      ST_IDLE: begin
        if (start) begin
          words_nxt = '0;
          if (length != '0) begin
            ptr_nxt       = base_addr;
            remaining_nxt = length;
            busy_nxt      = 1'b1;
            state_nxt     = ST_LOAD;
          end else begin
            state_nxt = ST_FINISH;
          end
        end
      end

      ST_LOAD: begin
        if (accept) begin
          we_nxt        = 1'b1;
          wr_addr_nxt   = ptr;
          wr_data_nxt   = in_data;
          ptr_nxt       = ptr + ADDR_WIDTH'(1);
          remaining_nxt = remaining - CNT_W'(1);
          words_nxt     = words_written + CNT_W'(1);
          if (remaining == CNT_W'(1)) begin
            state_nxt = ST_FINISH;
          end
        end
      end

      // FINISH overlaps the last write strobe; done lands one cycle later.
      ST_FINISH: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_stream_loader.sv
// Directed self-checking bench for ram_stream_loader: streaming loads, gaps,
// address wrap, zero length, ignored restart, mid-load reset, full-depth load.
module tb_ram_stream_loader;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = AW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] length;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          we;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic [CW-1:0] words_written;

  ram_stream_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .we(we),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            c;
  } wr_t;

  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  ready_cnt = 0;
  wr_t wq[$];
  int  done_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Observer: log every write strobe and done pulse with its cycle number.
  always @(negedge clk) begin
    if (we === 1'b1) wq.push_back('{wr_addr, wr_data, cyc});
    if (done === 1'b1) done_q.push_back(cyc);
    if (in_ready === 1'b1) ready_cnt <= ready_cnt + 1;
  end

  task automatic start_load(input logic [AW-1:0] b, input logic [CW-1:0] len,
                            output int c0, output int w0, output int d0, output int r0);
    @(negedge clk);
    c0 = cyc; w0 = wq.size(); d0 = done_q.size(); r0 = ready_cnt;
    start = 1'b1; base_addr = b; length = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_stream(input int n, input logic [DW-1:0] dbase, input bit gappy,
                            input int restart_at, output int sent);
    int k = 0;
    sent = 0;
    while (sent < n && k < 1000) begin
      in_valid = gappy ? ((k % 2) == 0) : 1'b1;
      in_data  = dbase + DW'(sent);
      if (k == restart_at) begin
        start = 1'b1; base_addr = 8'h80; length = CW'(2);
      end else begin
        start = 1'b0;
      end
      if (in_valid && in_ready) sent++;
      @(negedge clk);
      k++;
    end
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({in_ready, we, wr_addr, wr_data, busy, done, words_written} !== '0)
      begin bad++; $display("FAIL reset_outputs got=%b/%b/%h/%h/%b/%b/%0d exp=all zero",
                            in_ready, we, wr_addr, wr_data, busy, done, words_written); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int c0, w0, d0, r0, sent;
    logic [AW-1:0] ea;
    start_load(8'h10, CW'(4), c0, w0, d0, r0);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", busy); end
    run_stream(4, 32'hA0, 1'b0, -1, sent);
    repeat (3) @(negedge clk);
    total++;
    if (wq.size() - w0 !== 4) begin bad++; $display("FAIL basic_count got=%0d exp=4", wq.size() - w0); end
    else begin
      for (int i = 0; i < 4; i++) begin
        ea = AW'(8'h10 + i);
        total++;
        if (wq[w0+i].a !== ea || wq[w0+i].d !== 32'hA0 + DW'(i) || wq[w0+i].c !== c0 + 2 + i)
          begin bad++; $display("FAIL basic_write%0d got=%h/%h@%0d exp=%h/%h@%0d", i,
                                wq[w0+i].a, wq[w0+i].d, wq[w0+i].c, ea, 32'hA0 + DW'(i), c0 + 2 + i); end
      end
      total++;
      if (done_q.size() - d0 !== 1 || done_q[d0] !== wq[w0+3].c + 1)
        begin bad++; $display("FAIL basic_done_timing got=%0d pulses exp=1 at %0d", done_q.size() - d0, wq[w0+3].c + 1); end
    end
    total++;
    if (words_written !== CW'(4) || busy !== 1'b0)
      begin bad++; $display("FAIL basic_final got=%0d/%b exp=4/0", words_written, busy); end
    total++;
    if (wr_addr !== 8'h13 || wr_data !== 32'hA3)
      begin bad++; $display("FAIL basic_hold got=%h/%h exp=13/a3", wr_addr, wr_data); end
  endtask

  task automatic test_gaps();
    int c0, w0, d0, r0, sent;
    start_load(8'h10, CW'(4), c0, w0, d0, r0);
    run_stream(4, 32'hB0, 1'b1, -1, sent);
    repeat (3) @(negedge clk);
    total++;
    if (wq.size() - w0 !== 4) begin bad++; $display("FAIL gaps_count got=%0d exp=4", wq.size() - w0); end
    else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (wq[w0+i].a !== AW'(8'h10 + i) || wq[w0+i].d !== 32'hB0 + DW'(i) || wq[w0+i].c !== c0 + 2 + 2 * i)
          begin bad++; $display("FAIL gaps_write%0d got=%h/%h@%0d exp=%h/%h@%0d", i,
                                wq[w0+i].a, wq[w0+i].d, wq[w0+i].c, 8'h10 + i, 32'hB0 + i, c0 + 2 + 2 * i); end
      end
    end
    total++;
    if (done_q.size() - d0 !== 1) begin bad++; $display("FAIL gaps_done got=%0d exp=1", done_q.size() - d0); end
  endtask

  task automatic test_wrap();
    int c0, w0, d0, r0, sent;
    logic [AW-1:0] exp_a [4];
    exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00; exp_a[3] = 8'h01;
    start_load(8'hFE, CW'(4), c0, w0, d0, r0);
    run_stream(4, 32'hC0, 1'b0, -1, sent);
    repeat (4) @(negedge clk);
    total++;
    if (wq.size() - w0 !== 4) begin bad++; $display("FAIL wrap_count got=%0d exp=4", wq.size() - w0); end
    else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (wq[w0+i].a !== exp_a[i] || wq[w0+i].d !== 32'hC0 + DW'(i))
          begin bad++; $display("FAIL wrap_write%0d got=%h/%h exp=%h/%h", i, wq[w0+i].a, wq[w0+i].d, exp_a[i], 32'hC0 + i); end
      end
    end
  endtask

  task automatic test_zero_length();
    int c0, w0, d0, r0;
    start_load(8'h55, CW'(0), c0, w0, d0, r0);
    in_valid = 1'b1; in_data = 32'hDEAD;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (wq.size() !== w0) begin bad++; $display("FAIL zero_no_write got=%0d exp=0", wq.size() - w0); end
    total++;
    if (ready_cnt !== r0) begin bad++; $display("FAIL zero_ready got=%0d exp=0 ready cycles", ready_cnt - r0); end
    total++;
    if (done_q.size() - d0 !== 1 || done_q[d0] !== c0 + 2)
      begin bad++; $display("FAIL zero_done got=%0d pulses exp=1 at %0d", done_q.size() - d0, c0 + 2); end
    total++;
    if (busy !== 1'b0 || words_written !== '0)
      begin bad++; $display("FAIL zero_state got=%b/%0d exp=0/0", busy, words_written); end
  endtask

  task automatic test_restart_ignored();
    int c0, w0, d0, r0, sent;
    start_load(8'h20, CW'(5), c0, w0, d0, r0);
    run_stream(5, 32'hD0, 1'b0, 2, sent);
    repeat (6) @(negedge clk);
    total++;
    if (wq.size() - w0 !== 5) begin bad++; $display("FAIL restart_count got=%0d exp=5", wq.size() - w0); end
    else begin
      total++;
      if (wq[w0].a !== 8'h20 || wq[w0+4].a !== 8'h24 || wq[w0+4].d !== 32'hD4)
        begin bad++; $display("FAIL restart_addr got=%h..%h/%h exp=20..24/d4", wq[w0].a, wq[w0+4].a, wq[w0+4].d); end
    end
    total++;
    if (words_written !== CW'(5) || done_q.size() - d0 !== 1 || in_ready !== 1'b0)
      begin bad++; $display("FAIL restart_final got=%0d/%0d/%b exp=5/1/0", words_written, done_q.size() - d0, in_ready); end
  endtask

  task automatic test_mid_reset();
    int c0, w0, d0, r0, sent, r1;
    start_load(8'h30, CW'(5), c0, w0, d0, r0);
    run_stream(2, 32'hE0, 1'b0, -1, sent);
    rst = 1'b1; in_valid = 1'b1; in_data = 32'hEE;
    @(negedge clk);
    total++;
    if ({in_ready, we, wr_addr, wr_data, busy, done, words_written} !== '0)
      begin bad++; $display("FAIL midrst_outputs got=%b/%b/%h/%h/%b/%b/%0d exp=all zero",
                            in_ready, we, wr_addr, wr_data, busy, done, words_written); end
    rst = 1'b0;
    r1 = ready_cnt;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (wq.size() - w0 !== 2) begin bad++; $display("FAIL midrst_writes got=%0d exp=2", wq.size() - w0); end
    total++;
    if (ready_cnt !== r1 || done_q.size() !== d0 || busy !== 1'b0)
      begin bad++; $display("FAIL midrst_idle got=%0d ready/%0d done/%b exp=0/0/0", ready_cnt - r1, done_q.size() - d0, busy); end
  endtask

  task automatic test_full_depth();
    int c0, w0, d0, r0, sent, errs;
    int seen [256];
    foreach (seen[i]) seen[i] = 0;
    start_load(8'h37, CW'(256), c0, w0, d0, r0);
    run_stream(256, 32'h1000, 1'b0, -1, sent);
    repeat (3) @(negedge clk);
    for (int i = w0; i < wq.size(); i++) seen[wq[i].a]++;
    errs = 0;
    foreach (seen[i]) if (seen[i] != 1) errs++;
    total++;
    if (wq.size() - w0 !== 256 || errs !== 0)
      begin bad++; $display("FAIL full_cover got=%0d writes %0d bad addrs exp=256/0", wq.size() - w0, errs); end
    total++;
    if (words_written !== CW'(256) || done_q.size() - d0 !== 1)
      begin bad++; $display("FAIL full_final got=%0d/%0d exp=256/1", words_written, done_q.size() - d0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_wrap();
    test_zero_length();
    test_restart_ignored();
    test_mid_reset();
    test_full_depth();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
